// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. A 16-bit value and a decimal-point mask are double buffered:
// loads land in a shadow register, and the shadow is committed to the active
// register only when the scan wraps from digit 3 back to digit 0. This means
// a frame never shows a mix of old and new digits. Each digit slot opens with
// a short all-off guard interval to suppress ghosting between digits.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot, guard included (>= 2)
//   GUARD_CYC    cycles at the start of each slot with every anode off
//                (< REFRESH_DIV)
//   LZB_EN       1 = blank leading-zero digits, 0 = always show all digits
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   load       in   1   one-cycle strobe: capture value/dp_mask into shadow
//   value      in   16  number to show; [3:0] is digit 0 (rightmost)
//   dp_mask    in   4   1 = light the decimal point of that digit
//   enable     in   1   0 = force the display dark (scan keeps running)
//   hex        out  4   nibble of the digit being scanned, to the decoder
//   an         out  4   anodes, active-low; an[d] drives digit d
//   dp         out  1   decimal point, active-low
//   digit_sel  out  2   index of the digit being scanned
//
// Every output is a flop loaded from next-state values, so the outputs in a
// given cycle line up with the cnt/digit values of that same cycle.
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 16,
    parameter int LZB_EN      = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        enable,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  GUARD_END = CW'(GUARD_CYC);

    // State
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [1:0]    digit_q,      digit_d;
    logic [15:0]   shadow_val_q, shadow_val_d;
    logic [3:0]    shadow_dp_q,  shadow_dp_d;
    logic [15:0]   active_val_q, active_val_d;
    logic [3:0]    active_dp_q,  active_dp_d;

    // Registered outputs
    logic [3:0]    hex_q, hex_d;
    logic [3:0]    an_q,  an_d;
    logic          dp_q,  dp_d;

    // Helpers
    logic          slot_end;
    logic          frame_end;
    logic          on_phase;
    logic          lit;
    logic [3:0]    blank;

    always_comb begin
        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (digit_q == 2'd3);

        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        digit_d = slot_end ? digit_q + 2'd1 : digit_q;

        // Last load wins in the shadow register.
        shadow_val_d = load ? value   : shadow_val_q;
        shadow_dp_d  = load ? dp_mask : shadow_dp_q;

        // Committing shadow_*_d (rather than shadow_*_q) means a load on the
        // same edge as the 3->0 wrap goes straight into the new frame.
        active_val_d = frame_end ? shadow_val_d : active_val_q;
        active_dp_d  = frame_end ? shadow_dp_d  : active_dp_q;

        // Leading-zero blanking: digit d blanks when nibbles d..3 are all
        // zero. Digit 0 is never blanked, so zero still shows "0".
        blank = 4'b0000;
        if (LZB_EN != 0) begin
            blank[3] = (active_val_d[15:12] == 4'h0);
            blank[2] = blank[3] && (active_val_d[11:8] == 4'h0);
            blank[1] = blank[2] && (active_val_d[7:4]  == 4'h0);
        end

        on_phase = (cnt_d >= GUARD_END);
        lit      = on_phase && enable && !blank[digit_d];

        hex_d = active_val_d[{digit_d, 2'b00} +: 4];

        an_d = 4'b1111;
        if (lit) begin
            an_d[digit_d] = 1'b0;
        end

        dp_d = !(lit && active_dp_d[digit_d]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            active_val_q <= 16'h0000;
            active_dp_q  <= 4'h0;
            hex_q        <= 4'h0;
            an_q         <= 4'b1111;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            hex_q        <= hex_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign hex       = hex_q;
    assign an        = an_q;
    assign dp        = dp_q;
    assign digit_sel = digit_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Directed bench for display_scan_ctrl with REFRESH_DIV = 8, GUARD_CYC = 2,
// LZB_EN = 1. One frame is 4 slots of 8 cycles = 32 cycles. The bench
// keeps its own count n of rising edges since reset release, so the
// expected scan position is cnt = n % 8, digit = (n / 8) % 4. Inputs are
// driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        enable;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_sel;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    localparam int NONE = 99;

    display_scan_ctrl #(
        .REFRESH_DIV (8),
        .GUARD_CYC   (2),
        .LZB_EN      (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .value     (value),
        .dp_mask   (dp_mask),
        .enable    (enable),
        .hex       (hex),
        .an        (an),
        .dp        (dp),
        .digit_sel (digit_sel)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    // Checks one whole frame starting at digit 0, cnt 0. exp_val/shown/
    // exp_mask/exp_en describe what the frame must display; up to two loads
    // can be issued at given cycle indices within the frame (NONE = no load).
    // A load issued at index i is captured on the edge leaving index i.
    task automatic check_frame(
        input logic [15:0] exp_val,
        input logic [3:0]  shown,
        input logic [3:0]  exp_mask,
        input logic        exp_en,
        input int          la1,
        input logic [15:0] lv1,
        input logic [3:0]  lm1,
        input int          la2,
        input logic [15:0] lv2,
        input logic [3:0]  lm2
    );
        int         d;
        int         c;
        logic [3:0] an_e;
        logic       dp_e;
        logic [3:0] hex_e;
        for (int i = 0; i < 32; i++) begin
            d     = (n / 8) % 4;
            c     = n % 8;
            an_e  = 4'b1111;
            if (c >= 2 && exp_en && shown[d]) an_e[d] = 1'b0;
            dp_e  = !(an_e[d] == 1'b0 && exp_mask[d]);
            hex_e = exp_val[4*d +: 4];
            chk($sformatf("n%0d hex", n), hex, hex_e);
            chk($sformatf("n%0d an", n), an, an_e);
            chk($sformatf("n%0d dp", n), {3'b000, dp}, {3'b000, dp_e});
            chk($sformatf("n%0d digit_sel", n), {2'b00, digit_sel}, 4'(d));
            if (i == la1) begin
                value = lv1; dp_mask = lm1; load = 1'b1;
            end else if (i == la2) begin
                value = lv2; dp_mask = lm2; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        load    = 1'b0;
        value   = 16'h0000;
        dp_mask = 4'h0;
        enable  = 1'b1;

        // 1. reset asserted between edges acts immediately
        #2 reset_n = 1'b0;
        #1;
        chk("rst an", an, 4'b1111);
        chk("rst dp", {3'b000, dp}, 4'h1);
        chk("rst hex", hex, 4'h0);
        chk("rst digit_sel", {2'b00, digit_sel}, 4'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;

        // Frame 0: active = 0 -> "0" on digit 0 only
        check_frame(16'h0000, 4'b0001, 4'h0, 1'b1, NONE, 16'h0, 4'h0, NONE, 16'h0, 4'h0);
        // 2. frame 1 still 0 while 12AB is loaded; frame 2 shows it
        check_frame(16'h0000, 4'b0001, 4'h0, 1'b1, 0, 16'h12AB, 4'h0, NONE, 16'h0, 4'h0);
        // 3. leading-zero blanking; dp on a blanked digit stays dark
        check_frame(16'h12AB, 4'b1111, 4'h0, 1'b1, 3, 16'h0005, 4'hF, NONE, 16'h0, 4'h0);
        check_frame(16'h0005, 4'b0001, 4'hF, 1'b1, 5, 16'h0000, 4'h0, NONE, 16'h0, 4'h0);
        check_frame(16'h0000, 4'b0001, 4'h0, 1'b1, 9, 16'h0100, 4'h0, NONE, 16'h0, 4'h0);
        // 4. loads mid-frame do not tear; the last one wins
        check_frame(16'h0100, 4'b0111, 4'h0, 1'b1, 8, 16'h1111, 4'h0, 16, 16'h2222, 4'h0);
        // load coinciding with the 3->0 wrap shows in the new frame
        check_frame(16'h2222, 4'b1111, 4'h0, 1'b1, 31, 16'h1234, 4'b0100, NONE, 16'h0, 4'h0);
        // 5. dp only during the digit 2 ON window
        check_frame(16'h1234, 4'b1111, 4'b0100, 1'b1, NONE, 16'h0, 4'h0, NONE, 16'h0, 4'h0);
        // enable low: dark, scan keeps running
        enable = 1'b0;
        check_frame(16'h1234, 4'b1111, 4'b0100, 1'b0, NONE, 16'h0, 4'h0, NONE, 16'h0, 4'h0);
        enable = 1'b1;

        // 6. reset at digit 2, cnt 5
        repeat (21) tick();
        chk("pre-rst an", an, 4'b1011);
        chk("pre-rst hex", hex, 4'h2);
        chk("pre-rst dp", {3'b000, dp}, 4'h0);
        chk("pre-rst digit_sel", {2'b00, digit_sel}, 4'h2);
        reset_n = 1'b0;
        #1;
        chk("mid-rst an", an, 4'b1111);
        chk("mid-rst dp", {3'b000, dp}, 4'h1);
        chk("mid-rst hex", hex, 4'h0);
        chk("mid-rst digit_sel", {2'b00, digit_sel}, 4'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        // active and shadow both cleared: two frames of "0"
        check_frame(16'h0000, 4'b0001, 4'h0, 1'b1, NONE, 16'h0, 4'h0, NONE, 16'h0, 4'h0);
        check_frame(16'h0000, 4'b0001, 4'h0, 1'b1, NONE, 16'h0, 4'h0, NONE, 16'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
